// File: rtl/secded_decoder_engine.sv
// SECDED (16,11) decoder engine: reads a block of codewords from data memory, corrects
// single errors, flags double errors and writes {flag, data} words back; done on completion.
module secded_decoder_engine #(
  parameter int NUM_WORDS = 15,
  parameter int SRC_BASE  = 30,
  parameter int DST_BASE  = 0,
  parameter int ADDR_W    = 8
) (
  input  logic              clk,
  input  logic              reset,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [7:0]        mem_rd_data,
  output logic              mem_wr_en,
  output logic [7:0]        mem_wr_data,
  output logic              done,
  output logic [4:0]        err1_cnt,
  output logic [4:0]        err2_cnt
);

  localparam int IW = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;

  typedef enum logic [2:0] {RD_LO, RD_HI, DECODE, WR_LO, WR_HI, FINISH} state_t;

  state_t            state, state_nx;
  logic [IW-1:0]     idx;
  logic [15:0]       cw;
  logic [7:0]        out_lo, out_hi;
  logic              last;
  logic [ADDR_W-1:0] word_off, src_lo, dst_lo;

  logic [3:0]  syn;
  logic        par;
  logic [15:0] fixed;
  logic [10:0] data;
  logic [1:0]  flag;

  assign last     = (idx == IW'(NUM_WORDS - 1));
  assign word_off = ADDR_W'({idx, 1'b0});
  assign src_lo   = ADDR_W'(SRC_BASE) + word_off;
  assign dst_lo   = ADDR_W'(DST_BASE) + word_off;

  // Syndrome is the XOR of the positions of all set bits; overall parity picks single vs double.
  always_comb begin
    syn = '0;
    for (int unsigned k = 1; k < 16; k++) begin
      if (cw[k]) syn = syn ^ 4'(k);
    end
    par   = ^cw;
    fixed = cw;
    flag  = 2'b00;
    if (par) begin
      fixed = cw ^ (16'd1 << syn);
      flag  = 2'b01;
    end else if (syn != '0) begin
      flag  = 2'b10;
    end
    data = {fixed[15:9], fixed[7:5], fixed[3]};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= RD_LO;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      RD_LO:   state_nx = RD_HI;
      RD_HI:   state_nx = DECODE;
      DECODE:  state_nx = WR_LO;
      WR_LO:   state_nx = WR_HI;
      WR_HI:   state_nx = last ? FINISH : RD_LO;
      FINISH:  state_nx = FINISH;
      default: state_nx = RD_LO;
    endcase
  end

  always_comb begin
    mem_addr    = src_lo;
    mem_wr_en   = 1'b0;
    mem_wr_data = '0;
    case (state)
      RD_LO:         mem_addr = src_lo;
      RD_HI, DECODE: mem_addr = src_lo + ADDR_W'(1);
      WR_LO: begin
        mem_addr    = dst_lo;
        mem_wr_en   = 1'b1;
        mem_wr_data = out_lo;
      end
      WR_HI: begin
        mem_addr    = dst_lo + ADDR_W'(1);
        mem_wr_en   = 1'b1;
        mem_wr_data = out_hi;
      end
      FINISH:        mem_addr = dst_lo + ADDR_W'(1);
      default:       mem_addr = src_lo;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idx      <= '0;
      cw       <= '0;
      out_lo   <= '0;
      out_hi   <= '0;
      err1_cnt <= '0;
      err2_cnt <= '0;
      done     <= 1'b0;
    end else begin
      case (state)
        RD_LO: cw[7:0]  <= mem_rd_data;
        RD_HI: cw[15:8] <= mem_rd_data;
        DECODE: begin
          out_lo <= data[7:0];
          out_hi <= {flag, 3'b000, data[10:8]};
          if (flag == 2'b01 && err1_cnt != 5'd31) err1_cnt <= err1_cnt + 5'd1;
          if (flag == 2'b10 && err2_cnt != 5'd31) err2_cnt <= err2_cnt + 5'd1;
        end
        WR_HI: begin
          if (last) done <= 1'b1;
          else      idx  <= idx + IW'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_secded_decoder_engine.sv
// Scoreboard bench for secded_decoder_engine: expected writes are queued per run and a
// negedge monitor checks every memory write against the queue.
module tb_secded_decoder_engine;

  localparam int N   = 15;
  localparam int SRC = 30;
  localparam int DST = 0;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] mem_addr;
  logic [7:0] mem_rd_data;
  logic       mem_wr_en;
  logic [7:0] mem_wr_data;
  logic       done;
  logic [4:0] err1_cnt, err2_cnt;

  logic [7:0] mem [256];
  logic [7:0] exp_mem [2*N];

  typedef struct {
    logic [7:0] addr;
    logic [7:0] data;
  } wr_t;
  wr_t q[$];

  int n_vec = 0;
  int n_err = 0;
  int n_single, n_double;

  secded_decoder_engine #(
    .NUM_WORDS(N),
    .SRC_BASE(SRC),
    .DST_BASE(DST),
    .ADDR_W(8)
  ) dut (
    .clk(clk),
    .reset(reset),
    .mem_addr(mem_addr),
    .mem_rd_data(mem_rd_data),
    .mem_wr_en(mem_wr_en),
    .mem_wr_data(mem_wr_data),
    .done(done),
    .err1_cnt(err1_cnt),
    .err2_cnt(err2_cnt)
  );

  always #5 clk = ~clk;

  assign mem_rd_data = mem[mem_addr];
  always @(posedge clk) if (mem_wr_en) mem[mem_addr] <= mem_wr_data;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_vec++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  always @(negedge clk) begin
    wr_t e;
    if (!reset && mem_wr_en) begin
      if (q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_write: addr %0h data %0h", mem_addr, mem_wr_data);
      end else begin
        e = q.pop_front();
        chk("wr_addr", 32'(mem_addr), 32'(e.addr));
        chk("wr_data", 32'(mem_wr_data), 32'(e.data));
      end
    end
  end

  function automatic logic [15:0] encode(input logic [10:0] d);
    logic [15:0] c;
    logic [3:0]  s;
    c = '0;
    c[3]    = d[0];
    c[7:5]  = d[3:1];
    c[15:9] = d[10:4];
    s = '0;
    for (int k = 1; k < 16; k++) if (c[k]) s = s ^ 4'(k);
    c[1] = s[0];
    c[2] = s[1];
    c[4] = s[2];
    c[8] = s[3];
    c[0] = ^c[15:1];
    return c;
  endfunction

  function automatic logic [10:0] raw_data(input logic [15:0] c);
    return {c[15:9], c[7:5], c[3]};
  endfunction

  task automatic load_word(input int i, input logic [15:0] c, input logic [10:0] d, input logic [1:0] f);
    mem[SRC + 2*i]     = c[7:0];
    mem[SRC + 2*i + 1] = c[15:8];
    exp_mem[2*i]       = d[7:0];
    exp_mem[2*i + 1]   = {f, 3'b000, d[10:8]};
  endtask

  task automatic arm_run();
    q.delete();
    for (int i = 0; i < 2*N; i++) begin
      mem[DST + i] = 8'hEE;
      q.push_back('{addr: 8'(DST + i), data: exp_mem[i]});
    end
  endtask

  task automatic check_reset_state();
    #1;
    chk("rst_done", 32'(done), 0);
    chk("rst_wr_en", 32'(mem_wr_en), 0);
    chk("rst_addr", 32'(mem_addr), SRC);
    chk("rst_wr_data", 32'(mem_wr_data), 0);
    chk("rst_err1", 32'(err1_cnt), 0);
    chk("rst_err2", 32'(err2_cnt), 0);
  endtask

  task automatic wait_done(input int e1, input int e2);
    int cycles;
    cycles = 0;
    while (!done && cycles < 200) begin
      @(posedge clk);
      #1;
      cycles++;
    end
    chk("done_cycle", 32'(cycles), 75);
    chk("err1_cnt", 32'(err1_cnt), 32'(e1));
    chk("err2_cnt", 32'(err2_cnt), 32'(e2));
    chk("pending_writes", 32'(q.size()), 0);
    for (int i = 0; i < 2*N; i++) chk("final_mem", 32'(mem[DST + i]), 32'(exp_mem[i]));
  endtask

  task automatic full_run(input int e1, input int e2);
    reset = 1'b1;
    arm_run();
    @(negedge clk);
    check_reset_state();
    @(negedge clk);
    reset = 1'b0;
    wait_done(e1, e2);
  endtask

  initial begin
    logic [10:0] d;
    logic [15:0] c;
    int p1, p2;

    for (int i = 0; i < 256; i++) mem[i] = 8'h00;

    // Directed words from hand-decoded vectors, then clean fillers.
    load_word(0, 16'hB42D, 11'h5A3, 2'b00);
    load_word(1, 16'hB46D, 11'h5A3, 2'b01);
    load_word(2, 16'hB42C, 11'h5A3, 2'b01);
    load_word(3, 16'hB465, 11'h5A6, 2'b10);
    for (int i = 4; i < N; i++) begin
      d = 11'(i * 97 + 5);
      load_word(i, encode(d), d, 2'b00);
    end
    full_run(2, 1);

    // Random encoded messages: 3/4 single flips, 1/4 double flips.
    n_single = 0;
    n_double = 0;
    for (int i = 0; i < N; i++) begin
      d = 11'($urandom);
      c = encode(d);
      if ($urandom_range(3) != 0) begin
        p1 = int'($urandom_range(15));
        c[p1] = ~c[p1];
        load_word(i, c, d, 2'b01);
        n_single++;
      end else begin
        p1 = int'($urandom_range(15));
        p2 = (p1 + 1 + int'($urandom_range(14))) % 16;
        c[p1] = ~c[p1];
        c[p2] = ~c[p2];
        load_word(i, c, raw_data(c), 2'b10);
        n_double++;
      end
    end
    full_run(n_single, n_double);

    // Abort mid-run at edge 23, hold reset 2 cycles, then a full clean restart.
    reset = 1'b1;
    arm_run();
    @(negedge clk);
    reset = 1'b0;
    repeat (23) @(posedge clk);
    #1 reset = 1'b1;
    #1;
    chk("abort_done", 32'(done), 0);
    chk("abort_err1", 32'(err1_cnt), 0);
    chk("abort_err2", 32'(err2_cnt), 0);
    chk("abort_wr_en", 32'(mem_wr_en), 0);
    chk("abort_addr", 32'(mem_addr), SRC);
    chk("abort_pending", 32'(q.size()), 22);
    arm_run();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    wait_done(n_single, n_double);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/secded_decoder_engine.md
# secded_decoder_engine

Hardware SECDED decoder engine, the receive-side counterpart of the program-1 Hamming encoder. After reset it walks a block of 16-bit (16,11) Hamming codewords in data memory, corrects any single-bit error, detects double-bit errors, and writes the recovered 11-bit messages with a 2-bit status flag back into memory. It then asserts `done`, using the same reset-as-request and `done` handshake as `top_level`.

## Interface
- `NUM_WORDS`, 15: number of codewords processed.
- `SRC_BASE`, 30: byte address of the first codeword's low byte.
- `DST_BASE`, 0: byte address of the first decoded word's low byte.
- `ADDR_W`, 8: memory byte-address width.
- `clk`  in  1  clock; all state changes on rising edge.
- `reset`  in  1  asynchronous, active-high; also serves as the start request.
- `mem_addr`  out  ADDR_W  byte address to data memory.
- `mem_rd_data`  in  8  combinational read data for `mem_addr`, valid in the same cycle.
- `mem_wr_en`  out  1  write strobe; memory writes `mem_wr_data` at `mem_addr` on the rising edge.
- `mem_wr_data`  out  8  write data.
- `done`  out  1  registered; high once all words are written, held until reset.
- `err1_cnt`  out  5  count of words with a corrected single error.
- `err2_cnt`  out  5  count of words with a detected double error.

## Operation
- Codeword i:
  - low byte at `SRC_BASE+2i`, high byte at `SRC_BASE+2i+1`.
  - Bit layout [15:0] = {d11..d5, p8, d4..d2, p4, d1, p2, p1, p0}.
  - Bit k (k = 1..15) is Hamming position k; bit 0 is overall parity p0.
- Syndrome s[3:0] = XOR of indices k (1..15) whose received bit is 1. P = XOR of all 16 bits.
- Classification:
  - s=0, P=0: clean. flag=2'b00.
  - P=1: single error at position s. s=0 means p0 itself. Invert bit s, flag=2'b01, increment `err1_cnt`.
  - s≠0, P=0: double error. No correction, flag=2'b10, increment `err2_cnt`.
- Output word i:
  - Low byte = d[8:1], written to `DST_BASE+2i`.
  - High byte = {flag[1:0], 3'b000, d[11:9]}, written to `DST_BASE+2i+1`.
  - Data bits are taken after correction.
- FSM states: RD_LO, RD_HI, DECODE, WR_LO, WR_HI, FINISH.
  - RD_LO: `mem_addr`=SRC_BASE+2i; latch `mem_rd_data` into cw[7:0]; go to RD_HI.
  - RD_HI: `mem_addr`=SRC_BASE+2i+1; latch cw[15:8]; go to DECODE.
  - DECODE: compute s, P, corrected data and flag; register results and counters; go to WR_LO.
  - WR_LO: `mem_wr_en`=1, write low byte; go to WR_HI.
  - WR_HI: `mem_wr_en`=1, write high byte. If i = NUM_WORDS-1, go to FINISH; else i++ and go to RD_LO.
  - FINISH: `done`=1, `mem_wr_en`=0, `mem_addr` holds; remain until reset.
- Index counter i is $clog2(NUM_WORDS) bits wide. Address arithmetic is ADDR_W bits and wraps modulo 2^ADDR_W.
- Counters saturate at 31.

## Timing
- Reset values: state=RD_LO, i=0, `done`=0, `mem_wr_en`=0, `mem_addr`=SRC_BASE, `mem_wr_data`=0, `err1_cnt`=0, `err2_cnt`=0.
- `mem_addr`, `mem_wr_en` and `mem_wr_data` are driven combinationally from state and registers. `mem_wr_en` is high only in WR_LO and WR_HI.
- Each word takes exactly 5 cycles. The first rising edge after reset deassertion completes RD_LO of word 0.
- `done` rises on edge 5·NUM_WORDS after reset release (75 for defaults). It is high one cycle after the final WR_HI write commits.
- Reset asserted mid-operation immediately returns all registers to reset values. Partially written output stays in memory; no write occurs while reset is high. Processing restarts from word 0 on release.
- Source and destination regions are assumed disjoint. Overlapping regions are unsupported.

## Test plan
- Clean codeword 16'hB42D (d=11'h5A3) at word 0 -> bytes 8'hA3 at addr 0, 8'h05 at addr 1; both counters 0.
- Single data-bit flip 16'hB46D (bit 6) -> 8'hA3 at addr 0, 8'h45 at addr 1; `err1_cnt`=1.
- Parity-only flip 16'hB42C (bit 0) -> 8'hA3, 8'h45; data unchanged, `err1_cnt`=1.
- Double flip 16'hB465 (bits 6, 3) -> 8'hA6, 8'h85 (uncorrected data, flag 10); `err2_cnt`=1.
- Fill all 15 words with random encoded messages: 75% single flips, 25% double flips -> every output byte matches the reference model; `done` rises exactly 75 cycles after reset release.
- Assert reset at cycle 23 for 2 cycles -> `done`=0 and counters cleared immediately; after release, full 75-cycle run with correct final memory.
